instruction_fetcher: RTL and testbench

Per-core instruction fetcher and the reader of the program counter. Takes current_pc during the core's FETCH state and returns the 16-bit instruction to the decoder. Holds a small direct-mapped instruction buffer so loop bodies and branch targets skip the program-memory round trip. On a miss it is the initiator on the program-memory read channel, a valid/ready handshake to the program memory controller.

---
 rtl/instruction_fetcher.sv | 97 +++++++++
 tb/tb_instruction_fetcher.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetcher.sv
// Per-core instruction fetcher with a small direct-mapped instruction buffer.
// A buffer hit delivers the instruction one cycle after the FETCH lookup.
// A miss issues a valid/ready read to the program memory controller, then
// fills the buffer line with the returned instruction.
module instruction_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int BUFFER_ENTRIES        = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             invalidate,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction
);
  localparam int IDX_BITS = $clog2(BUFFER_ENTRIES);
  localparam int TAG_BITS = PROGRAM_MEM_ADDR_BITS - IDX_BITS;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    IDLE     = 3'b000,
    FETCHING = 3'b001,
    FETCHED  = 3'b010
  } state_t;

  state_t state;

  logic [PROGRAM_MEM_DATA_BITS-1:0] buf_data  [BUFFER_ENTRIES];
  logic [TAG_BITS-1:0]              buf_tag   [BUFFER_ENTRIES];
  logic [BUFFER_ENTRIES-1:0]        buf_valid;

  // Lookup uses the live PC; the fill uses the latched request address so a
  // PC change during an in-flight fetch cannot redirect the fill.
  logic [IDX_BITS-1:0] lk_idx, fill_idx;
  logic [TAG_BITS-1:0] lk_tag, fill_tag;
  logic                lk_hit;

  always_comb begin
    lk_idx   = current_pc[IDX_BITS-1:0];
    lk_tag   = current_pc[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
    fill_idx = mem_read_address[IDX_BITS-1:0];
    fill_tag = mem_read_address[PROGRAM_MEM_ADDR_BITS-1:IDX_BITS];
    lk_hit   = buf_valid[lk_idx] && (buf_tag[lk_idx] == lk_tag);
  end

  assign fetcher_state = state;

  // Fetch FSM, buffer fill and invalidate; invalidate is applied last so it
  // wins over a same-cycle fill. Buffer data/tags need no reset: valid gates them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
      buf_valid        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (core_state == CORE_FETCH) begin
            if (lk_hit) begin
              instruction <= buf_data[lk_idx];
              state       <= FETCHED;
            end else begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= current_pc;
              state            <= FETCHING;
            end
          end
        end
        FETCHING: begin
          if (mem_read_ready) begin
            instruction         <= mem_read_data;
            buf_data[fill_idx]  <= mem_read_data;
            buf_tag[fill_idx]   <= fill_tag;
            buf_valid[fill_idx] <= 1'b1;
            mem_read_valid      <= 1'b0;
            state               <= FETCHED;
          end
        end
        FETCHED: begin
          if (core_state == CORE_DECODE) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (invalidate) buf_valid <= '0;
    end
  end
endmodule

// File: tb/tb_instruction_fetcher.sv
// Bench for instruction_fetcher: directed scenarios plus random fetch traffic,
// checked against a PC-keyed model of a 4-line direct-mapped buffer.
module tb_instruction_fetcher;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int NB = 4;
  localparam logic [2:0] C_IDLE = 3'b000, C_FETCH = 3'b001, C_DECODE = 3'b010;

  logic          clk = 1'b0;
  logic          reset;
  logic [2:0]    core_state;
  logic [AW-1:0] current_pc;
  logic          invalidate;
  logic          mem_read_valid;
  logic [AW-1:0] mem_read_address;
  logic          mem_read_ready;
  logic [DW-1:0] mem_read_data;
  logic [2:0]    fetcher_state;
  logic [DW-1:0] instruction;

  instruction_fetcher #(.PROGRAM_MEM_ADDR_BITS(AW), .PROGRAM_MEM_DATA_BITS(DW),
                        .BUFFER_ENTRIES(NB)) dut (
    .clk(clk), .reset(reset), .core_state(core_state), .current_pc(current_pc),
    .invalidate(invalidate), .mem_read_valid(mem_read_valid),
    .mem_read_address(mem_read_address), .mem_read_ready(mem_read_ready),
    .mem_read_data(mem_read_data), .fetcher_state(fetcher_state),
    .instruction(instruction));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Program memory contents and buffer model: which PC each line holds.
  logic [DW-1:0] mem [256];
  bit            m_valid [NB];
  int            m_pc    [NB];

  function automatic void model_clear();
    for (int i = 0; i < NB; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic bit model_hit(input int pc);
    return m_valid[pc % NB] && (m_pc[pc % NB] == pc);
  endfunction

  // One full fetch: lookup, optional handshake wait, delivery, DECODE back to IDLE.
  task automatic do_fetch(input logic [AW-1:0] pc, input int waitc, input bit inv_at_ready,
                          input bit decode_during, output bit was_miss);
    bit exp_hit;
    logic [DW-1:0] exp_d;
    exp_hit = model_hit(pc);
    exp_d   = mem[pc];
    was_miss = !exp_hit;
    core_state = C_FETCH; current_pc = pc;
    @(negedge clk);
    if (exp_hit) begin
      n_checks++;
      if ({fetcher_state, mem_read_valid, instruction} !== {3'b010, 1'b0, exp_d}) begin
        n_fail++;
        $display("FAIL hit pc=%02h: state=%0d valid=%0b instr=%04h want state=2 valid=0 instr=%04h",
                 pc, fetcher_state, mem_read_valid, instruction, exp_d);
      end
    end else begin
      n_checks++;
      if ({mem_read_valid, mem_read_address, fetcher_state} !== {1'b1, pc, 3'b001}) begin
        n_fail++;
        $display("FAIL miss_req pc=%02h: valid=%0b addr=%02h state=%0d want valid=1 addr=%02h state=1",
                 pc, mem_read_valid, mem_read_address, fetcher_state, pc);
      end
      core_state = decode_during ? C_DECODE : C_FETCH;
      current_pc = AW'($urandom);
      for (int i = 0; i < waitc; i++) begin
        @(negedge clk);
        n_checks++;
        if ({mem_read_valid, mem_read_address, fetcher_state} !== {1'b1, pc, 3'b001}) begin
          n_fail++;
          $display("FAIL wait pc=%02h cyc=%0d: valid=%0b addr=%02h state=%0d want valid=1 addr=%02h state=1",
                   pc, i, mem_read_valid, mem_read_address, fetcher_state, pc);
        end
      end
      mem_read_ready = 1'b1; mem_read_data = exp_d; invalidate = inv_at_ready;
      @(negedge clk);
      mem_read_ready = 1'b0; invalidate = 1'b0; mem_read_data = DW'($urandom);
      n_checks++;
      if ({fetcher_state, mem_read_valid, instruction} !== {3'b010, 1'b0, exp_d}) begin
        n_fail++;
        $display("FAIL fill pc=%02h: state=%0d valid=%0b instr=%04h want state=2 valid=0 instr=%04h",
                 pc, fetcher_state, mem_read_valid, instruction, exp_d);
      end
      if (inv_at_ready) model_clear();
      else begin m_valid[pc % NB] = 1'b1; m_pc[pc % NB] = pc; end
    end
    core_state = C_DECODE;
    @(negedge clk);
    n_checks++;
    if ({fetcher_state, instruction} !== {3'b000, exp_d}) begin
      n_fail++;
      $display("FAIL to_idle pc=%02h: state=%0d instr=%04h want state=0 instr=%04h",
               pc, fetcher_state, instruction, exp_d);
    end
    core_state = C_IDLE;
  endtask

  task automatic pulse_inv();
    invalidate = 1'b1;
    @(negedge clk);
    invalidate = 1'b0;
    model_clear();
  endtask

  task automatic expect_miss(input string name, input bit was_miss);
    n_checks++;
    if (!was_miss) begin
      n_fail++;
      $display("FAIL %s: served as hit, want miss", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; core_state = C_IDLE; current_pc = '0; invalidate = 1'b0;
    mem_read_ready = 1'b0; mem_read_data = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if ({fetcher_state, mem_read_valid, mem_read_address, instruction} !== {3'b000, 1'b0, 8'h00, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset: state=%0d valid=%0b addr=%02h instr=%04h want all zero",
               fetcher_state, mem_read_valid, mem_read_address, instruction);
    end
    model_clear();
    // stray ready while idle must be ignored
    mem_read_ready = 1'b1; mem_read_data = 16'hDEAD;
    @(negedge clk);
    mem_read_ready = 1'b0;
    n_checks++;
    if ({fetcher_state, instruction} !== {3'b000, 16'h0000}) begin
      n_fail++;
      $display("FAIL stray_ready: state=%0d instr=%04h want state=0 instr=0000", fetcher_state, instruction);
    end
  endtask

  task automatic test_cold_miss_and_hit();
    bit m;
    pulse_inv();
    mem[8'h05] = 16'h3A17;
    do_fetch(8'h05, 3, 1'b0, 1'b0, m);
    expect_miss("cold_miss", m);
    do_fetch(8'h05, 0, 1'b0, 1'b0, m);
    n_checks++;
    if (m) begin n_fail++; $display("FAIL hit_expected: model reports miss, want hit"); end
  endtask

  task automatic test_conflict_eviction();
    bit m;
    pulse_inv();
    mem[8'h01] = 16'h1111; mem[8'h05] = 16'h5555;
    do_fetch(8'h01, 1, 1'b0, 1'b0, m);
    do_fetch(8'h05, 1, 1'b0, 1'b0, m);
    do_fetch(8'h01, 2, 1'b0, 1'b0, m);
    expect_miss("evict_01", m);
    do_fetch(8'h05, 0, 1'b0, 1'b0, m);
    expect_miss("evict_05", m);
  endtask

  task automatic test_backpressure();
    bit m;
    do_fetch(8'h20, 10, 1'b0, 1'b1, m);
    expect_miss("bp_20", m);
  endtask

  task automatic test_invalidate_collision();
    bit m;
    mem[8'h07] = 16'hBEEF;
    do_fetch(8'h07, 2, 1'b1, 1'b0, m);
    do_fetch(8'h07, 1, 1'b0, 1'b0, m);
    expect_miss("inv_collision_refetch", m);
  endtask

  task automatic test_reset_mid_fetch();
    bit m;
    // 0x07 is cached from the previous test
    do_fetch(8'h07, 0, 1'b0, 1'b0, m);
    core_state = C_FETCH; current_pc = 8'h33;
    repeat (3) @(negedge clk);
    reset = 1'b1; core_state = C_IDLE;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    n_checks++;
    if ({mem_read_valid, fetcher_state, instruction} !== {1'b0, 3'b000, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%0b state=%0d instr=%04h want 0/0/0000",
               mem_read_valid, fetcher_state, instruction);
    end
    do_fetch(8'h07, 1, 1'b0, 1'b0, m);
    expect_miss("after_reset_07", m);
  endtask

  task automatic test_random();
    bit m;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) pulse_inv();
      do_fetch(AW'($urandom_range(0, 15)), $urandom_range(0, 4),
               ($urandom_range(0, 7) == 0), $urandom_range(0, 1), m);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
    for (int i = 0; i < NB; i++) m_pc[i] = -1;
    test_reset();
    test_cold_miss_and_hit();
    test_conflict_eviction();
    test_backpressure();
    test_invalidate_collision();
    test_reset_mid_fetch();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
